// File: rtl/oam_dma.sv
// Sprite DMA bus initiator: a CPU write to DMA_REG_ADDR halts the CPU and copies
// one 256-byte page into PPU OAM through 256 writes to OAM_DATA_ADDR.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | bus passes through from the CPU, waiting for a trigger write
//  HALT  | CPU stalled, its current cycle still completes on the bus
//  ALIGN | dummy read so that the first READ lands on a get cycle
//  READ  | read byte {page,idx} into the latch
//  WRITE | write the latched byte to OAMDATA, advance idx
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter bit          ALIGN_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_rw_i,
  input  logic [7:0]  cpu_data_i,
  input  logic [7:0]  bus_rdata_i,
  output logic        halt_o,
  output logic [15:0] bus_addr_o,
  output logic        bus_rw_o,
  output logic [7:0]  bus_data_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        parity;
  logic [7:0]  idx;
  logic [7:0]  page;
  logic [7:0]  latch;
  logic        done_q;
  logic        trig;
  logic        last_write;

  assign trig       = (cpu_addr_i == DMA_REG_ADDR) && !cpu_rw_i;
  assign last_write = (state == S_WRITE) && (idx == 8'hFF);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      parity <= 1'b0;
      idx    <= 8'h00;
      page   <= 8'h00;
      latch  <= 8'h00;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      parity <= ~parity;
      done_q <= last_write;
      if ((state == S_IDLE) && trig) begin
        page <= cpu_data_i;
      end
      if (state == S_READ) begin
        latch <= bus_rdata_i;
      end
      // idx wraps from 8'hFF back to 0 on the final write
      if (state == S_WRITE) begin
        idx <= idx + 8'h01;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (trig) state_nx = S_HALT;
      // parity==1 now means the following cycle is a get cycle
      S_HALT:  state_nx = (parity || !ALIGN_EN) ? S_READ : S_ALIGN;
      S_ALIGN: state_nx = S_READ;
      S_READ:  state_nx = S_WRITE;
      S_WRITE: state_nx = (idx == 8'hFF) ? S_IDLE : S_READ;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    halt_o     = 1'b0;
    busy_o     = 1'b0;
    bus_addr_o = cpu_addr_i;
    bus_rw_o   = cpu_rw_i;
    bus_data_o = cpu_data_i;
    case (state)
      S_HALT: begin
        halt_o = 1'b1;
      end
      S_ALIGN, S_READ: begin
        halt_o     = 1'b1;
        busy_o     = 1'b1;
        bus_addr_o = {page, idx};
        bus_rw_o   = 1'b1;
      end
      S_WRITE: begin
        halt_o     = 1'b1;
        busy_o     = 1'b1;
        bus_addr_o = OAM_DATA_ADDR;
        bus_rw_o   = 1'b0;
        bus_data_o = latch;
      end
      default: ;
    endcase
  end

  assign done_o = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Randomized scoreboard bench for oam_dma: stimulus pushes the expected bus
// reads, OAM writes and halt length per transfer; a negedge monitor pops them.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_data;
  logic [7:0]  bus_rdata;
  logic        halt_o;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic [7:0]  bus_data;
  logic        busy_o;
  logic        done_o;

  oam_dma dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr_i  (cpu_addr),
    .cpu_rw_i    (cpu_rw),
    .cpu_data_i  (cpu_data),
    .bus_rdata_i (bus_rdata),
    .halt_o      (halt_o),
    .bus_addr_o  (bus_addr),
    .bus_rw_o    (bus_rw),
    .bus_data_o  (bus_data),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign bus_rdata = mem[bus_addr];

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [15:0] rq[$];
  logic [23:0] wq[$];
  int          xq[$];
  bit          abort = 1'b1;
  bit          p_model = 1'b0;
  int          halt_cnt = 0;
  int          wr_xfer = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // parity: cleared by reset, toggles on every other edge
  always @(posedge clk) p_model <= rst ? ~p_model : 1'b0;

  always @(negedge clk) begin
    if (abort) begin
      rq.delete();
      wq.delete();
      xq.delete();
      halt_cnt = 0;
      wr_xfer  = 0;
    end else begin
      if (halt_o) halt_cnt++;
      if (busy_o) begin
        if (!halt_o) check("busy_without_halt", 0, 1);
        if (bus_rw) begin
          if (rq.size() == 0) check("unexpected_read", int'(bus_addr), -1);
          else check("dma_read_addr", int'(bus_addr), int'(rq.pop_front()));
        end else begin
          if (wq.size() == 0) check("unexpected_write", int'({bus_addr, bus_data}), -1);
          else check("oam_write", int'({bus_addr, bus_data}), int'(wq.pop_front()));
          wr_xfer++;
        end
      end else begin
        check("passthru", int'({bus_addr, bus_rw, bus_data}), int'({cpu_addr, cpu_rw, cpu_data}));
      end
      if (done_o) begin
        if (xq.size() == 0) check("unexpected_done", 1, 0);
        else check("halt_cycles", halt_cnt, xq.pop_front());
        check("writes_per_xfer", wr_xfer, 256);
        halt_cnt = 0;
        wr_xfer  = 0;
      end
    end
  end

  task automatic rand_cpu();
    cpu_addr = 16'($urandom);
    if (cpu_addr == 16'h4014) cpu_addr = 16'h4015;
    cpu_rw   = 1'($urandom);
    cpu_data = 8'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rand_cpu();
  endtask

  task automatic align_to(input bit want_p);
    if (p_model != want_p) step();
  endtask

  // Drive the trigger for one cycle; the HALT cycle then carries parity ~p_model,
  // so an alignment read is needed exactly when p_model is 1 now.
  task automatic trigger(input logic [7:0] pg);
    bit         al;
    logic [7:0] b;
    al       = p_model;
    cpu_addr = 16'h4014;
    cpu_rw   = 1'b0;
    cpu_data = pg;
    if (al) rq.push_back({pg, 8'h00});
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      rq.push_back({pg, b});
      wq.push_back({16'h2004, mem[{pg, b}]});
    end
    xq.push_back(al ? 514 : 513);
    step();
  endtask

  task automatic wait_done(input bit inject);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 700 && !got; c++) begin
      step();
      if (done_o) got = 1'b1;
      else if (inject && $urandom_range(0, 7) == 0) begin
        cpu_addr = 16'h4014;
        cpu_rw   = 1'b0;
      end
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic wait_writes(input int n);
    for (int c = 0; c < 700 && wr_xfer < n; c++) step();
    if (wr_xfer < n) check("writes_timeout", wr_xfer, n);
  endtask

  task automatic reset_checks(input string tag);
    #1;
    check({tag, "_halt"}, int'(halt_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
    check({tag, "_addr"}, int'(bus_addr), int'(cpu_addr));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
    rand_cpu();
    rst = 1'b0;
    repeat (3) begin
      step();
      if ($urandom_range(0, 1) == 1) begin
        cpu_addr = 16'h4014;
        cpu_rw   = 1'b0;
      end
      reset_checks("reset");
    end
    rst = 1'b1;
    step();
    abort = 1'b0;
    repeat (2) step();

    align_to(1'b0);
    trigger(8'h02);
    wait_done(1'b1);

    repeat (3) step();
    align_to(1'b1);
    trigger(8'h02);
    wait_done(1'b1);
    // retrigger on the done cycle itself
    trigger(8'($urandom));
    wait_done(1'b0);

    step();
    trigger(8'hFF);
    wait_done(1'b0);

    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(1, 4)) step();
      trigger(8'($urandom));
      wait_done(1'b1);
    end

    step();
    trigger(8'h02);
    wait_writes(100);
    rst   = 1'b0;
    abort = 1'b1;
    step();
    reset_checks("abort");
    step();
    rst = 1'b1;
    step();
    abort = 1'b0;
    step();
    trigger(8'h02);
    wait_done(1'b0);

    repeat (3) step();
    check("rq_drained", rq.size(), 0);
    check("wq_drained", wq.size(), 0);
    check("xq_drained", xq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
